lif_spike_monitor: RTL

- Observation stage directly downstream of the HLS LIF neuron core; consumes its 1-bit spike output.
- Over a programmable window of enabled cycles it measures spike count, last inter-spike interval (ISI) and minimum ISI.
- Results are read through a byte-wide muxed port that maps onto the TinyTapeout uo_out/uio pins.

---
 rtl/lif_spike_monitor.sv | 92 +++++++++
 1 files changed

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: windowed spike count and inter-spike interval statistics for a LIF core output
module lif_spike_monitor #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spike_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [1:0]       rd_sel,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             isi_valid,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  state_t state, state_nx;
  logic spike_d, first_seen;
  logic [CNT_W-1:0] spike_cnt;
  logic [ISI_W-1:0] isi_last, isi_min, isi_run;
  logic [WIN_W-1:0] win_cnt;
  logic spk_edge, accept, run;
  assign spk_edge = spike_in & ~spike_d;
  assign accept = ena & start & (state != COUNT);
  assign run = ena & (state == COUNT);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state: start from IDLE/HOLD opens a window, the last counted cycle closes it
  always_comb begin
    state_nx = state;
    if (accept) state_nx = (window_len != '0) ? COUNT : HOLD;
    else if (run && win_cnt == WIN_W'(1)) state_nx = HOLD;
  end
  // state-decoded outputs
  always_comb begin
    busy = (state == COUNT);
    done = (state == HOLD);
  end
  // measurement datapath; isi_run restarts at 1 on an edge so it reads b-a at the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_d <= 1'b0;
      spike_cnt <= '0;
      isi_last <= '0;
      isi_min <= '1;
      isi_run <= '0;
      first_seen <= 1'b0;
      isi_valid <= 1'b0;
      overflow <= 1'b0;
      win_cnt <= '0;
    end else if (ena) begin
      spike_d <= spike_in;
      if (accept) begin
        spike_cnt <= '0;
        isi_last <= '0;
        isi_min <= '1;
        isi_run <= '0;
        first_seen <= 1'b0;
        isi_valid <= 1'b0;
        overflow <= 1'b0;
        win_cnt <= window_len;
      end else if (run) begin
        win_cnt <= win_cnt - WIN_W'(1);
        isi_run <= spk_edge ? ISI_W'(1) : (&isi_run ? isi_run : isi_run + ISI_W'(1));
        if (spk_edge) begin
          spike_cnt <= &spike_cnt ? spike_cnt : spike_cnt + CNT_W'(1);
          if (&spike_cnt) overflow <= 1'b1;
          if (first_seen) begin
            isi_last <= isi_run;
            isi_min <= (isi_run < isi_min) ? isi_run : isi_min;
            isi_valid <= 1'b1;
          end
          first_seen <= 1'b1;
        end
      end
    end
  end
  // byte-wide readout mux
  always_comb begin
    rd_data = (rd_sel == 2'd0) ? 8'(spike_cnt) :
              (rd_sel == 2'd1) ? 8'(isi_last) :
              (rd_sel == 2'd2) ? 8'(isi_min) :
              {4'b0, isi_valid, overflow, done, busy};
  end
endmodule
